// File: rtl/fixed_point_pkg.sv
// Shared Q-format definitions for the ODE accelerator fixed-point datapath.
// Default format is Q5.10 in 16 bits; arithmetic is format-agnostic.
package fixed_point_pkg;

  localparam int FP_WIDTH     = 16;
  localparam int FP_FRAC_BITS = 10;

  localparam logic [FP_WIDTH-1:0] FP_MAX = 16'h7FFF;
  localparam logic [FP_WIDTH-1:0] FP_MIN = 16'h8000;

  typedef logic signed [FP_WIDTH-1:0] fp_t;

endpackage

// File: rtl/fixed_point_add_core.sv
// Combinational two's-complement add/subtract with signed-overflow detection.
// Provides both the wrapped and the clamped result so callers pick a policy.
module fixed_point_add_core
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH-1:0] sum_raw,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] b_eff;
  logic [WIDTH:0] sum_ext;

  // Negation is done at WIDTH+1 bits so that -MIN is representable (+2^(W-1))
  assign a_ext   = {A[WIDTH-1], A};
  assign b_ext   = {B[WIDTH-1], B};
  assign b_eff   = sub ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
  assign sum_ext = a_ext + b_eff;

  assign sum_raw  = sum_ext[WIDTH-1:0];
  assign overflow = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

  always_comb begin
    sum_sat = sum_raw;
    if (overflow) begin
      sum_sat = sum_ext[WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/fixed_point_adder.sv
// Registered fixed-point adder: one-cycle latency, one op per cycle,
// optional saturation, outputs hold their value while idle.
module fixed_point_adder
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int FRAC_BITS = FP_FRAC_BITS,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_sat;
  logic [WIDTH-1:0] sum_sel;
  logic             ovf;

  // The binary point only matters to software; reject formats that cannot exist
  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_format
    $error("fixed_point_adder: FRAC_BITS must lie in [0, WIDTH-1]");
  end

  fixed_point_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A        (A),
    .B        (B),
    .sub      (sub),
    .sum_raw  (sum_raw),
    .overflow (ovf),
    .sum_sat  (sum_sat)
  );

  if (SATURATE != 0) begin : g_sat
    assign sum_sel = sum_sat;
  end else begin : g_wrap
    assign sum_sel = sum_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= '0;
      overflow_flag <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result        <= sum_sel;
        overflow_flag <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_adder.sv
// Directed and streaming checks of fixed_point_adder in wrap and saturate builds,
// both instances driven from the same operand bus.
module tb_fixed_point_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] res_w, res_s;
  logic        ovf_w, ovf_s;
  logic        vld_w, vld_s;

  int n_vec;
  int n_fail;

  fixed_point_adder #(.WIDTH(16), .FRAC_BITS(10), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
    .result(res_w), .overflow_flag(ovf_w), .out_valid(vld_w)
  );

  fixed_point_adder #(.WIDTH(16), .FRAC_BITS(10), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
    .result(res_s), .overflow_flag(ovf_s), .out_valid(vld_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] wrap;
    logic        ovf;
    logic [15:0] sat;
  } vec_t;

  // Integer reference: the exact difference/sum, then range-checked
  function automatic logic [32:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    int ra, rb, r;
    logic [15:0] w, sv;
    logic        o;
    ra = int'($signed(a));
    rb = int'($signed(b));
    r  = s ? (ra - rb) : (ra + rb);
    w  = r[15:0];
    o  = (r > 32767) || (r < -32768);
    sv = (r > 32767) ? 16'h7FFF : ((r < -32768) ? 16'h8000 : w);
    return {o, w, sv};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; sub = 1'b0; A = 16'h1234; B = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({vld_w, ovf_w, res_w, vld_s, ovf_s, res_s} !== 36'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: wrap v/o/r=%b/%b/%h sat v/o/r=%b/%b/%h, required all zero",
                 i, vld_w, ovf_w, res_w, vld_s, ovf_s, res_s);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({vld_w, ovf_w, res_w} !== {1'b1, 1'b0, 16'h1234} ||
        {vld_s, ovf_s, res_s} !== {1'b1, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL reset_release: wrap %b/%b/%h sat %b/%b/%h, required 1/0/1234",
               vld_w, ovf_w, res_w, vld_s, ovf_s, res_s);
    end
    in_valid = 1'b0; A = 16'h5555; B = 16'h5555;
    @(posedge clk); #1;
    n_vec++;
    if ({vld_w, ovf_w, res_w} !== {1'b0, 1'b0, 16'h1234} ||
        {vld_s, ovf_s, res_s} !== {1'b0, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL idle_hold: wrap %b/%b/%h sat %b/%b/%h, required 0/0/1234",
               vld_w, ovf_w, res_w, vld_s, ovf_s, res_s);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[11];
    vecs[0]  = {16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 16'h0003};
    vecs[1]  = {16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[2]  = {16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b1, 16'h7FFF};
    vecs[3]  = {16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 16'h8000};
    vecs[4]  = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h8000};
    vecs[5]  = {16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 16'h0002};
    vecs[6]  = {16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'h7FFF};
    vecs[7]  = {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = {16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 16'h7FFF};
    vecs[9]  = {16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 16'h8000};
    vecs[10] = {16'h0400, 16'h0200, 1'b0, 16'h0600, 1'b0, 16'h0600};
    // Back-to-back: each result must be present for exactly its own cycle
    for (int i = 0; i < 11; i++) begin
      A = vecs[i].a; B = vecs[i].b; sub = vecs[i].sub; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({vld_w, ovf_w, res_w} !== {1'b1, vecs[i].ovf, vecs[i].wrap} ||
          {vld_s, ovf_s, res_s} !== {1'b1, vecs[i].ovf, vecs[i].sat}) begin
        n_fail++;
        $display("FAIL directed[%0d] %h %s %h: wrap %b/%b/%h sat %b/%b/%h, required 1/%b/%h and 1/%b/%h",
                 i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b,
                 vld_w, ovf_w, res_w, vld_s, ovf_s, res_s,
                 vecs[i].ovf, vecs[i].wrap, vecs[i].ovf, vecs[i].sat);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    logic [32:0] g;
    logic [15:0] exp_w, exp_s;
    logic        exp_o, exp_v;
    exp_w = res_w; exp_s = res_s; exp_o = ovf_w;
    // Seed the held model from the known idle state left by test_directed
    exp_w = 16'h0600; exp_s = 16'h0600; exp_o = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        rst_n = 1'b0; in_valid = 1'b1;
        #1;
        n_vec++;
        if ({vld_w, ovf_w, res_w, vld_s, ovf_s, res_s} !== 36'h0) begin
          n_fail++;
          $display("FAIL stream_reset_flush: wrap %b/%b/%h sat %b/%b/%h, required all zero",
                   vld_w, ovf_w, res_w, vld_s, ovf_s, res_s);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        exp_w = 16'h0; exp_s = 16'h0; exp_o = 1'b0;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      A   = 16'($urandom);
      B   = 16'($urandom);
      sub = 1'($urandom);
      if (i % 10 == 3) A = 16'h8000;
      if (i % 10 == 7) B = 16'h8000;
      exp_v = in_valid;
      if (in_valid) begin
        g = golden(A, B, sub);
        exp_o = g[32]; exp_w = g[31:16]; exp_s = g[15:0];
      end
      @(posedge clk); #1;
      n_vec++;
      if ({vld_w, ovf_w, res_w} !== {exp_v, exp_o, exp_w} ||
          {vld_s, ovf_s, res_s} !== {exp_v, exp_o, exp_s}) begin
        n_fail++;
        $display("FAIL stream[%0d]: wrap %b/%b/%h sat %b/%b/%h, required %b/%b/%h and %b/%b/%h",
                 i, vld_w, ovf_w, res_w, vld_s, ovf_s, res_s,
                 exp_v, exp_o, exp_w, exp_v, exp_o, exp_s);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; A = '0; B = '0;
    #1;
    test_reset();
    test_directed();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
